// File: rtl/branch_resolve_if.sv
// branch_resolve_if: execute-stage branch inputs and fetch/flush control outputs
interface branch_resolve_if;
  logic        stall;
  logic [3:0]  br_expect;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic [31:0] pc_exe;
  logic [31:0] imm;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        busy;
  logic [31:0] br_count;
  logic [31:0] taken_count;
  modport master (
    output stall, br_expect, data_a, data_b, pc_exe, imm,
    input  redirect, redirect_pc, flush, busy, br_count, taken_count
  );
  modport slave (
    input  stall, br_expect, data_a, data_b, pc_exe, imm,
    output redirect, redirect_pc, flush, busy, br_count, taken_count
  );
endinterface

// File: rtl/branch_resolve_ctl.sv
// branch_resolve_ctl: resolves conditional branches at execute, redirects fetch and flushes shadow instrs; BRANCH_RESOLVE_STATS_EN enables counters
module branch_resolve_ctl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  branch_resolve_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] sum;
  logic        is_br, cond, eval, take;
  // branch decode, compare and target; only IDLE with no stall evaluates
  always_comb begin
    sum   = bus.pc_exe + bus.imm;
    is_br = bus.br_expect >= 4'd1 && bus.br_expect <= 4'd6;
    case (bus.br_expect)
      4'd1:    cond = bus.data_a == bus.data_b;
      4'd2:    cond = bus.data_a != bus.data_b;
      4'd3:    cond = $signed(bus.data_a) <  $signed(bus.data_b);
      4'd4:    cond = $signed(bus.data_a) >= $signed(bus.data_b);
      4'd5:    cond = bus.data_a <  bus.data_b;
      4'd6:    cond = bus.data_a >= bus.data_b;
      default: cond = 1'b0;
    endcase
    eval = state_q == IDLE && !bus.stall && is_br;
    take = eval && cond;
  end
  // next state, flush countdown and captured target
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      IDLE: begin
        state_d       = take ? REDIRECT : IDLE;
        redirect_pc_d = take ? {sum[31:1], 1'b0} : redirect_pc_q;
      end
      REDIRECT: begin
        state_d = FLUSH;
        cnt_d   = CNT_INIT;
      end
      FLUSH: begin
        state_d = (!bus.stall && cnt_q == 4'd0) ? IDLE : FLUSH;
        cnt_d   = (!bus.stall && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      redirect_pc_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end
  // outputs decoded from state
  always_comb begin
    bus.redirect    = state_q == REDIRECT;
    bus.flush       = state_q != IDLE;
    bus.busy        = state_q != IDLE;
    bus.redirect_pc = redirect_pc_q;
  end
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] br_count_q, br_count_d, taken_count_q, taken_count_d;
  // saturating counts of evaluated and taken branches
  always_comb begin
    br_count_d    = (eval && br_count_q != '1) ? br_count_q + 32'd1 : br_count_q;
    taken_count_d = (take && taken_count_q != '1) ? taken_count_q + 32'd1 : taken_count_q;
  end
  // statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count_q    <= 32'd0;
      taken_count_q <= 32'd0;
    end else begin
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
    end
  end
  assign bus.br_count    = br_count_q;
  assign bus.taken_count = taken_count_q;
`else
  assign bus.br_count    = 32'd0;
  assign bus.taken_count = 32'd0;
`endif
endmodule

// File: tb/tb_branch_resolve_ctl.sv
// tb_branch_resolve_ctl: directed vectors with a scoreboard queue and a negedge monitor
module tb_branch_resolve_ctl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  branch_resolve_if bus();
  branch_resolve_ctl #(.FLUSH_CYCLES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct packed {
    logic        rd;
    logic        fl;
    logic [31:0] pc;
    logic [31:0] bc;
    logic [31:0] tc;
  } exp_t;
  exp_t q[$];
  int vecs = 0;
  int errs = 0;
  logic [31:0] n_br = 32'd0;
  logic [31:0] n_tk = 32'd0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] pc, input logic [31:0] im, input logic st,
                     input logic rd, input logic fl, input logic [31:0] epc,
                     input logic ev, input logic tk);
    @(negedge clk);
    #1;
    bus.br_expect = code;
    bus.data_a    = a;
    bus.data_b    = b;
    bus.pc_exe    = pc;
    bus.imm       = im;
    bus.stall     = st;
    n_br += 32'(ev);
    n_tk += 32'(tk);
`ifdef BRANCH_RESOLVE_STATS_EN
    q.push_back(exp_t'{rd, fl, epc, n_br, n_tk});
`else
    q.push_back(exp_t'{rd, fl, epc, 32'd0, 32'd0});
`endif
  endtask
  task automatic nop(input logic st, input logic fl, input logic [31:0] epc);
    cyc(4'd0, 32'd0, 32'd0, 32'd0, 32'd0, st, 1'b0, fl, epc, 1'b0, 1'b0);
  endtask
  task automatic chk_reset();
    chk("rst_redirect", 32'(bus.redirect), 32'd0);
    chk("rst_flush", 32'(bus.flush), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("rst_br_count", bus.br_count, 32'd0);
    chk("rst_taken_count", bus.taken_count, 32'd0);
  endtask
  exp_t e;
  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("redirect", 32'(bus.redirect), 32'(e.rd));
      chk("flush", 32'(bus.flush), 32'(e.fl));
      chk("busy", 32'(bus.busy), 32'(e.fl));
      chk("redirect_pc", bus.redirect_pc, e.pc);
      chk("br_count", bus.br_count, e.bc);
      chk("taken_count", bus.taken_count, e.tc);
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.stall = 1'b0;
    bus.br_expect = 4'd0;
    bus.data_a = 32'd0;
    bus.data_b = 32'd0;
    bus.pc_exe = 32'd0;
    bus.imm = 32'd0;
    #1;
    chk_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nop(1'b0, 1'b0, 32'h0);
    cyc(4'd1, 32'd5, 32'd5, 32'h100, 32'h10, 1'b0, 1'b1, 1'b1, 32'h110, 1'b1, 1'b1);
    nop(1'b0, 1'b1, 32'h110);
    nop(1'b0, 1'b1, 32'h110);
    nop(1'b0, 1'b0, 32'h110);
    cyc(4'd3, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h8, 1'b0, 1'b1, 1'b1, 32'h208, 1'b1, 1'b1);
    nop(1'b0, 1'b1, 32'h208);
    nop(1'b0, 1'b1, 32'h208);
    nop(1'b0, 1'b0, 32'h208);
    cyc(4'd5, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h8, 1'b0, 1'b0, 1'b0, 32'h208, 1'b1, 1'b0);
    cyc(4'd7, 32'd9, 32'd9, 32'h600, 32'h4, 1'b0, 1'b0, 1'b0, 32'h208, 1'b0, 1'b0);
    cyc(4'd1, 32'd9, 32'd9, 32'h600, 32'h4, 1'b1, 1'b0, 1'b0, 32'h208, 1'b0, 1'b0);
    cyc(4'd1, 32'd1, 32'd2, 32'h600, 32'h4, 1'b0, 1'b0, 1'b0, 32'h208, 1'b1, 1'b0);
    cyc(4'd2, 32'd1, 32'd2, 32'h300, 32'h20, 1'b0, 1'b1, 1'b1, 32'h320, 1'b1, 1'b1);
    cyc(4'd6, 32'd3, 32'd3, 32'h400, 32'h4, 1'b0, 1'b0, 1'b1, 32'h320, 1'b0, 1'b0);
    cyc(4'd6, 32'd3, 32'd3, 32'h400, 32'h4, 1'b0, 1'b0, 1'b1, 32'h320, 1'b0, 1'b0);
    nop(1'b0, 1'b0, 32'h320);
    cyc(4'd4, 32'd5, 32'hFFFFFFFD, 32'h500, 32'hFFFFFFF0, 1'b0, 1'b1, 1'b1, 32'h4F0, 1'b1, 1'b1);
    nop(1'b0, 1'b1, 32'h4F0);
    nop(1'b1, 1'b1, 32'h4F0);
    nop(1'b0, 1'b1, 32'h4F0);
    nop(1'b0, 1'b0, 32'h4F0);
    cyc(4'd1, 32'd0, 32'd0, 32'hFFFFFFF0, 32'h21, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 1'b1);
    nop(1'b1, 1'b1, 32'h10);
    nop(1'b0, 1'b1, 32'h10);
    nop(1'b0, 1'b0, 32'h10);
    cyc(4'd4, 32'hFFFFFFFD, 32'd5, 32'h700, 32'h100, 1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 1'b0);
    cyc(4'd6, 32'hFFFFFFFD, 32'd5, 32'h700, 32'h100, 1'b0, 1'b1, 1'b1, 32'h800, 1'b1, 1'b1);
    nop(1'b0, 1'b1, 32'h800);
    nop(1'b0, 1'b1, 32'h800);
    nop(1'b0, 1'b0, 32'h800);
    cyc(4'd1, 32'd7, 32'd7, 32'h1000, 32'h40, 1'b0, 1'b1, 1'b1, 32'h1040, 1'b1, 1'b1);
    nop(1'b0, 1'b1, 32'h1040);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset();
    n_br = 32'd0;
    n_tk = 32'd0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    nop(1'b0, 1'b0, 32'h0);
    cyc(4'd1, 32'd7, 32'd7, 32'h2000, 32'h8, 1'b0, 1'b1, 1'b1, 32'h2008, 1'b1, 1'b1);
    nop(1'b0, 1'b1, 32'h2008);
    nop(1'b0, 1'b1, 32'h2008);
    nop(1'b0, 1'b0, 32'h2008);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() > 0) begin
      errs++;
      $display("FAIL drain: %0d expected entries left unchecked", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/branch_resolve_ctl.md
BRANCH_RESOLVE_CTL -- requirements
Module: branch_resolve_ctl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter FLUSH_CYCLES, 2, number of cycles flush is held after redirect (legal 1..15).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 stall  in  1  pipeline stall; freezes evaluation and flush counting.
REQ-006 br_expect  in  4  branch code from execute control: 0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, others treated as none.
REQ-007 data_a  in  32  rs1 operand at execute.
REQ-008 data_b  in  32  rs2 operand at execute.
REQ-009 pc_exe  in  32  PC of the instruction at execute.
REQ-010 imm  in  32  sign-extended B-type immediate.
REQ-011 redirect  out  1  one-cycle pulse: fetch loads redirect_pc.
REQ-012 redirect_pc  out  32  branch target.
REQ-013 flush  out  1  kill younger instructions in decode/execute.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 br_count  out  32  resolved conditional branches (feature-gated).
REQ-016 taken_count  out  32  taken conditional branches (feature-gated).

Function
REQ-017 Compare: BEQ a==b; BNE a!=b; BLT/BGE signed a<b / a>=b; BLTU/BGEU unsigned a<b / a>=b.
REQ-018 Target = (pc_exe + imm) mod 2^32 with bit 0 forced to 0.
REQ-019 States: IDLE, REDIRECT, FLUSH.
REQ-020 IDLE, stall=0, valid code, condition true -> next edge: REDIRECT, redirect=1, redirect_pc=target, flush=1.
REQ-021 IDLE, condition false, code none, or stall=1 -> remain IDLE; redirect=0, flush=0, redirect_pc holds.
REQ-022 REDIRECT lasts exactly one cycle regardless of stall; next edge -> FLUSH with counter loaded to FLUSH_CYCLES-1.
REQ-023 FLUSH: flush=1, redirect=0; counter decrements only when stall=0; leave to IDLE on the edge where counter==0 and stall=0.
REQ-024 FLUSH_CYCLES=1 -> REDIRECT goes to FLUSH for exactly one unstalled cycle, then IDLE.
REQ-025 In REDIRECT and FLUSH, br_expect is ignored: no evaluation, no redirect, no count (shadow instructions are being killed).
REQ-026 Latency: condition sampled at edge N -> redirect high N..N+1; flush high from N for 1+FLUSH_CYCLES unstalled cycles.
REQ-027 A taken branch presented in the first IDLE cycle after FLUSH is accepted normally (back-to-back allowed).
REQ-028 redirect_pc is registered; stable until the next accepted taken branch.

Reset
REQ-029 rst_n low asynchronously forces state IDLE, redirect=0, flush=0, busy=0, redirect_pc=0, counter=0, br_count=0, taken_count=0.
REQ-030 Reset mid-REDIRECT/FLUSH aborts immediately; first edge after release evaluates normally from IDLE.

Configuration
REQ-031 Macro BRANCH_RESOLVE_STATS_EN defined: br_count increments per evaluated conditional branch (IDLE, stall=0, code 1..6); taken_count increments per taken one; both saturate at 0xFFFFFFFF.
REQ-032 Macro undefined: br_count and taken_count are constant 0, no counter flops.

Verification
REQ-033 BEQ, a=b=0x00000005, pc=0x00000100, imm=0x00000010 -> redirect 1 cycle, redirect_pc=0x00000110, flush 3 cycles (FLUSH_CYCLES=2), busy 3 cycles.
REQ-034 BLT a=0xFFFFFFFF, b=1 -> taken; BLTU same operands -> not taken, redirect=0, flush=0.
REQ-035 Taken BNE then BGEU (a=3,b=3) held in the following two cycles -> only the first redirect; br_count=1, taken_count=1 with macro defined.
REQ-036 Taken BGE, stall=1 during first FLUSH cycle -> flush extends by one cycle (4 total); redirect still single cycle.
REQ-037 pc=0xFFFFFFF0, imm=0x00000021 -> redirect_pc=0x00000010 (wrap, bit0 cleared).
REQ-038 rst_n low in FLUSH -> flush and busy drop without waiting for clk; taken BEQ one cycle after release redirects normally.
